// File: rtl/fgp_fb_writer.sv
// FGP payload unpacker: turns the parser's byte stream into one 12-bit framebuffer
// write per pixel at {offset, pixel_index}, and flags packet/frame completion and errors.
module fgp_fb_writer #(
   parameter int              BYTE_LEN          = 8,
   parameter int              COLOR_WIDTH       = 12,
   parameter int              PIXELS_PER_PACKET = 512,
   parameter int              ADDR_WIDTH        = 17,
   parameter logic [BYTE_LEN-1:0] LAST_OFFSET   = 8'd255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   offset_inclk,
   input  logic [BYTE_LEN-1:0]    offset_in,
   input  logic                   inclk,
   input  logic [BYTE_LEN-1:0]    in,
   input  logic                   in_done,
   output logic                   ram_we,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   output logic [COLOR_WIDTH-1:0] ram_din,
   output logic                   pkt_done,
   output logic                   frame_done,
   output logic                   err
);

   localparam int IDX_W = $clog2(PIXELS_PER_PACKET);

   typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

   state_t                 state_q, state_d;
   logic [BYTE_LEN-1:0]    offset_q, offset_d;
   logic [IDX_W-1:0]       idx, idx_d;
   logic [BYTE_LEN-1:0]    hold, hold_d;
   logic [3:0]             nib, nib_d;
   logic                   bad, bad_d;
   logic                   we_d, pkt_d, frame_d, err_d;
   logic [ADDR_WIDTH-1:0]  addr_d;
   logic [COLOR_WIDTH-1:0] din_d;
   logic                   last, completing;

   assign last       = (idx == IDX_W'(PIXELS_PER_PACKET - 1));
   assign completing = inclk && !offset_inclk && (state_q == B2) && last;

   // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      idx_d    = idx;
      hold_d   = hold;
      nib_d    = nib;
      bad_d    = bad;
      we_d     = 1'b0;
      addr_d   = ram_addr;
      din_d    = ram_din;
      pkt_d    = 1'b0;
      frame_d  = 1'b0;
      err_d    = 1'b0;

      if (offset_inclk) begin
         // A new offset always opens a packet; any coincident data byte is dropped.
         err_d    = (state_q != IDLE);
         offset_d = offset_in;
         idx_d    = '0;
         bad_d    = 1'b0;
         state_d  = B0;
      end else if (inclk) begin
         case (state_q)
            IDLE: err_d = 1'b1;
            B0: begin
               hold_d  = in;
               state_d = B1;
            end
            B1: begin
               we_d    = 1'b1;
               addr_d  = {offset_q, idx};
               din_d   = {hold, in[7:4]};
               nib_d   = in[3:0];
               idx_d   = idx + 1'b1;
               state_d = B2;
            end
            default: begin
               we_d   = 1'b1;
               addr_d = {offset_q, idx};
               din_d  = {nib, in};
               if (last) begin
                  state_d = IDLE;
                  if (!in_done) begin
                     err_d = 1'b1;
                  end else if (!bad) begin
                     pkt_d   = 1'b1;
                     frame_d = (offset_q == LAST_OFFSET);
                  end
               end else begin
                  idx_d   = idx + 1'b1;
                  state_d = B0;
               end
            end
         endcase
      end

      // A stray end-of-payload marks the open packet so it never reports completion.
      if (in_done && !completing) begin
         err_d = 1'b1;
         if (!offset_inclk) bad_d = 1'b1;
      end
   end

   // NOTE: state and outputs update with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         offset_q   <= '0;
         idx        <= '0;
         hold       <= '0;
         nib        <= '0;
         bad        <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         pkt_done   <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         offset_q   <= offset_d;
         idx        <= idx_d;
         hold       <= hold_d;
         nib        <= nib_d;
         bad        <= bad_d;
         ram_we     <= we_d;
         ram_addr   <= addr_d;
         ram_din    <= din_d;
         pkt_done   <= pkt_d;
         frame_done <= frame_d;
         err        <= err_d;
      end
   end

endmodule

// File: tb/tb_fgp_fb_writer.sv
// Directed bench for fgp_fb_writer: packets are built from known pixel lists, and the
// logged RAM writes and pulses are compared against the expected writes and counts.
module tb_fgp_fb_writer;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        offset_inclk = 1'b0, inclk = 1'b0, in_done = 1'b0;
   logic [7:0]  offset_in = 8'h00, in_b = 8'h00;
   logic        ram_we, pkt_done, frame_done, err;
   logic [16:0] ram_addr;
   logic [11:0] ram_din;

   int n_checks = 0, n_pass = 0, cyc = 0;

   logic [16:0] mon_addr[$], exp_addr[$];
   logic [11:0] mon_data[$], exp_data[$];
   int          mon_cyc[$], exp_cyc[$], pkt_q[$], frame_q[$], err_q[$];

   fgp_fb_writer dut (
      .clk(clk), .rst_n(rst_n), .offset_inclk(offset_inclk), .offset_in(offset_in),
      .inclk(inclk), .in(in_b), .in_done(in_done), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .pkt_done(pkt_done), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Outputs are logged mid-cycle, well away from the active edge.
   always @(negedge clk) begin
      if (ram_we) begin
         mon_addr.push_back(ram_addr);
         mon_data.push_back(ram_din);
         mon_cyc.push_back(cyc);
      end
      if (pkt_done)   pkt_q.push_back(cyc);
      if (frame_done) frame_q.push_back(cyc);
      if (err)        err_q.push_back(cyc);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
      exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
      pkt_q.delete(); frame_q.delete(); err_q.delete();
   endtask

   // Describes the first logged write that differs from the expected list, or "" if none.
   function automatic string write_diff();
      for (int i = 0; i < mon_addr.size() && i < exp_addr.size(); i++)
         if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i] || mon_cyc[i] != exp_cyc[i])
            return $sformatf("write %0d got %h/%h@%0d want %h/%h@%0d", i, mon_addr[i],
                             mon_data[i], mon_cyc[i], exp_addr[i], exp_data[i], exp_cyc[i]);
      return "";
   endfunction

   // Offset strobe then n payload bytes packed from a pixel list; expected writes are queued.
   task automatic send_stream(input logic [7:0] off, input int n, input int max_gap,
                              input bit pattern, input int done_pos, input bit collide);
      logic [11:0] pix [512];
      logic [11:0] p0, p1;
      logic [7:0]  b;
      int          k;
      for (int i = 0; i < 512; i++)
         pix[i] = pattern ? ((i % 2 == 0) ? 12'hABC : 12'hDEF) : 12'($urandom);
      offset_in = off; offset_inclk = 1'b1; inclk = collide; in_b = 8'h99;
      tick();
      offset_inclk = 1'b0; inclk = 1'b0;
      for (int j = 0; j < n; j++) begin
         k  = j / 3;
         p0 = pix[2*k];
         p1 = pix[2*k+1];
         case (j % 3)
            0:       b = p0[11:4];
            1:       b = {p0[3:0], p1[11:8]};
            default: b = p1[7:0];
         endcase
         if (j % 3 == 1) begin
            exp_addr.push_back({off, 9'(2*k)}); exp_data.push_back(p0); exp_cyc.push_back(cyc + 1);
         end else if (j % 3 == 2) begin
            exp_addr.push_back({off, 9'(2*k+1)}); exp_data.push_back(p1); exp_cyc.push_back(cyc + 1);
         end
         in_b = b; inclk = 1'b1; in_done = (j == done_pos);
         tick();
         inclk = 1'b0; in_done = 1'b0;
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      n_checks++;
      if ({ram_we, pkt_done, frame_done, err} !== 4'b0)
         $display("FAIL reset_pulses: got %b want 0000", {ram_we, pkt_done, frame_done, err});
      else n_pass++;
      n_checks++;
      if ({ram_addr, ram_din} !== 29'h0)
         $display("FAIL reset_addr_din: got %h/%h want 0/0", ram_addr, ram_din);
      else n_pass++;
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_back_to_back();
      string d;
      clear_logs();
      send_stream(8'h05, 768, 0, 1'b1, 767, 1'b0);
      repeat (3) tick();
      d = write_diff();
      n_checks++;
      if (mon_addr.size() != 512) $display("FAIL b2b_count: got %0d want 512", mon_addr.size());
      else n_pass++;
      n_checks++;
      if (d != "") $display("FAIL b2b_writes: %s", d); else n_pass++;
      n_checks++;
      if (mon_addr[0] !== 17'h00A00 || mon_data[0] !== 12'hABC || mon_data[1] !== 12'hDEF)
         $display("FAIL b2b_first: got %h %h %h want 00a00 abc def", mon_addr[0], mon_data[0], mon_data[1]);
      else n_pass++;
      n_checks++;
      if (mon_addr[511] !== 17'h00BFF) $display("FAIL b2b_last_addr: got %h want 00bff", mon_addr[511]);
      else n_pass++;
      n_checks++;
      if (pkt_q.size() != 1 || pkt_q[0] != exp_cyc[511])
         $display("FAIL b2b_pkt_done: got %0d pulses, want 1 at cycle %0d", pkt_q.size(), exp_cyc[511]);
      else n_pass++;
      n_checks++;
      if (frame_q.size() != 0 || err_q.size() != 0)
         $display("FAIL b2b_no_frame_err: got frame %0d err %0d want 0 0", frame_q.size(), err_q.size());
      else n_pass++;
   endtask

   task automatic test_gaps();
      string d;
      clear_logs();
      send_stream(8'hFF, 768, 5, 1'b0, 767, 1'b0);
      repeat (3) tick();
      d = write_diff();
      n_checks++;
      if (mon_addr.size() != 512) $display("FAIL gap_count: got %0d want 512", mon_addr.size());
      else n_pass++;
      n_checks++;
      if (d != "") $display("FAIL gap_writes: %s", d); else n_pass++;
      n_checks++;
      if (mon_addr[511] !== 17'h1FFFF) $display("FAIL gap_last_addr: got %h want 1ffff", mon_addr[511]);
      else n_pass++;
      n_checks++;
      if (pkt_q.size() != 1 || frame_q.size() != 1 || frame_q[0] != exp_cyc[511])
         $display("FAIL gap_frame_done: got pkt %0d frame %0d want 1 1 at cycle %0d",
                  pkt_q.size(), frame_q.size(), exp_cyc[511]);
      else n_pass++;
      n_checks++;
      if (err_q.size() != 0) $display("FAIL gap_err: got %0d want 0", err_q.size()); else n_pass++;
   endtask

   task automatic test_truncated();
      string d;
      int    off_cyc;
      clear_logs();
      send_stream(8'h01, 100, 0, 1'b1, -1, 1'b0);
      off_cyc = cyc;
      send_stream(8'h02, 768, 0, 1'b1, 767, 1'b0);
      repeat (3) tick();
      d = write_diff();
      n_checks++;
      if (mon_addr.size() != 578) $display("FAIL trunc_count: got %0d want 578", mon_addr.size());
      else n_pass++;
      n_checks++;
      if (d != "") $display("FAIL trunc_writes: %s", d); else n_pass++;
      n_checks++;
      if (mon_addr[65] !== 17'h00241 || mon_addr[66] !== 17'h00400 || mon_addr[577] !== 17'h005FF)
         $display("FAIL trunc_bounds: got %h %h %h want 00241 00400 005ff",
                  mon_addr[65], mon_addr[66], mon_addr[577]);
      else n_pass++;
      n_checks++;
      if (err_q.size() != 1 || err_q[0] != off_cyc + 1)
         $display("FAIL trunc_err: got %0d pulses, want 1 at cycle %0d", err_q.size(), off_cyc + 1);
      else n_pass++;
      n_checks++;
      if (pkt_q.size() != 1 || frame_q.size() != 0)
         $display("FAIL trunc_pkt: got pkt %0d frame %0d want 1 0", pkt_q.size(), frame_q.size());
      else n_pass++;
   endtask

   task automatic test_idle_bytes();
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         in_b = 8'(8'h30 + i); inclk = 1'b1;
         tick();
         inclk = 1'b0;
      end
      repeat (3) tick();
      n_checks++;
      if (mon_addr.size() != 0) $display("FAIL idle_writes: got %0d want 0", mon_addr.size());
      else n_pass++;
      n_checks++;
      if (err_q.size() != 3) $display("FAIL idle_err: got %0d want 3", err_q.size()); else n_pass++;
   endtask

   task automatic test_collide();
      string d;
      clear_logs();
      send_stream(8'h22, 768, 0, 1'b1, 767, 1'b1);
      repeat (3) tick();
      d = write_diff();
      n_checks++;
      if (err_q.size() != 0) $display("FAIL collide_err: got %0d want 0", err_q.size()); else n_pass++;
      n_checks++;
      if (mon_addr.size() != 512) $display("FAIL collide_count: got %0d want 512", mon_addr.size());
      else n_pass++;
      n_checks++;
      if (d != "") $display("FAIL collide_writes: %s", d); else n_pass++;
      n_checks++;
      if (mon_addr[0] !== 17'h04400 || pkt_q.size() != 1)
         $display("FAIL collide_first: got addr %h pkt %0d want 04400 1", mon_addr[0], pkt_q.size());
      else n_pass++;
   endtask

   task automatic test_stray_done();
      clear_logs();
      send_stream(8'h03, 768, 0, 1'b1, 10, 1'b0);
      repeat (3) tick();
      n_checks++;
      if (mon_addr.size() != 512) $display("FAIL stray_count: got %0d want 512", mon_addr.size());
      else n_pass++;
      n_checks++;
      if (err_q.size() != 2 || pkt_q.size() != 0)
         $display("FAIL stray_err_pkt: got err %0d pkt %0d want 2 0", err_q.size(), pkt_q.size());
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      string d;
      clear_logs();
      send_stream(8'h33, 399, 0, 1'b1, -1, 1'b0);
      tick();
      in_b = 8'h5A; inclk = 1'b1; rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ram_we, ram_addr, ram_din, pkt_done, frame_done, err} !== 33'h0)
         $display("FAIL midrst_outputs: got we %b addr %h din %h want 0 0 0", ram_we, ram_addr, ram_din);
      else n_pass++;
      tick();
      inclk = 1'b0; rst_n = 1'b1;
      repeat (3) tick();
      d = write_diff();
      n_checks++;
      if (mon_addr.size() != 266 || d != "")
         $display("FAIL midrst_partial: got %0d writes %s want 266", mon_addr.size(), d);
      else n_pass++;
      send_stream(8'h10, 768, 0, 1'b0, 767, 1'b0);
      repeat (3) tick();
      d = write_diff();
      n_checks++;
      if (mon_addr.size() != 778 || d != "")
         $display("FAIL midrst_fresh: got %0d writes %s want 778", mon_addr.size(), d);
      else n_pass++;
      n_checks++;
      if (mon_addr[266] !== 17'h02000 || mon_addr[777] !== 17'h021FF)
         $display("FAIL midrst_bounds: got %h %h want 02000 021ff", mon_addr[266], mon_addr[777]);
      else n_pass++;
      n_checks++;
      if (pkt_q.size() != 1 || err_q.size() != 0)
         $display("FAIL midrst_pkt_err: got pkt %0d err %0d want 1 0", pkt_q.size(), err_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_truncated();
      test_idle_bytes();
      test_collide();
      test_stray_done();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fgp_fb_writer.md
# fgp_fb_writer

Consumer directly downstream of the FGP receive parser. Takes the parser's offset strobe and payload byte stream, unpacks each 768-byte payload into 512 twelve-bit colors, and issues one framebuffer RAM write per color at address `{offset, pixel_index}`. It also detects malformed packets and reports packet and frame completion to the display logic.

## Interface
Parameters:
- `BYTE_LEN`, 8, byte width.
- `COLOR_WIDTH`, 12, color width; the packing scheme is fixed for 12.
- `PIXELS_PER_PACKET`, 512, colors per payload (768 bytes).
- `ADDR_WIDTH`, 17, RAM address width: 8 offset bits plus 9 index bits.
- `LAST_OFFSET`, 8'd255, offset whose completion ends a frame.

Ports:
- `clk`, in, 1: system clock. One clock domain only.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `offset_inclk`, in, 1: offset byte valid strobe, one cycle.
- `offset_in`, in, `BYTE_LEN`: offset byte.
- `inclk`, in, 1: payload byte valid strobe, one cycle.
- `in`, in, `BYTE_LEN`: payload byte.
- `in_done`, in, 1: parser's end-of-payload strobe. Coincides with the 768th `inclk`.
- `ram_we`, out, 1: RAM write enable, registered.
- `ram_addr`, out, `ADDR_WIDTH`: RAM write address, registered.
- `ram_din`, out, `COLOR_WIDTH`: RAM write data, registered.
- `pkt_done`, out, 1: one-cycle pulse when a well-formed packet has fully written.
- `frame_done`, out, 1: one-cycle pulse, `pkt_done` for a packet with offset `LAST_OFFSET`.
- `err`, out, 1: one-cycle pulse on a protocol violation.

## Operation
- State machine states:
  - `IDLE`: no open packet.
  - `B0`: expecting byte 0 of a triplet.
  - `B1`: expecting byte 1 of a triplet.
  - `B2`: expecting byte 2 of a triplet.
- Registers:
  - `offset_q` (8 bits)
  - `idx` (9 bits, pixel index)
  - `hold` (8 bits, byte 0)
  - `nib` (4 bits, low nibble of byte 1)
- Packing, big-endian nibble order:
  - byte0 = p0[11:4]
  - byte1 = {p0[3:0], p1[11:8]}
  - byte2 = p1[7:0]
- Transitions on the strobes:
  - `offset_inclk` in `IDLE`: latch `offset_q`, `idx<=0`, go to `B0`.
  - `inclk` in `B0`: `hold<=in`, go to `B1`.
  - `inclk` in `B1`: write p0 = {hold, in[7:4]} at {offset_q, idx}; `nib<=in[3:0]`; `idx<=idx+1`; go to `B2`.
  - `inclk` in `B2`: write p1 = {nib, in} at {offset_q, idx}.
    - If `idx==511`: packet complete, pulse `pkt_done`, go to `IDLE`.
    - Otherwise `idx<=idx+1`, go to `B0`.
- `idx` is exactly 9 bits. It never wraps within a well-formed packet; completion is decided at `idx==511`.
- Violations: each pulses `err` exactly once, and no `pkt_done` is issued for the affected packet.
  - `inclk` in `IDLE`: byte dropped, state unchanged.
  - `offset_inclk` in `B0`/`B1`/`B2` (truncated packet): writes already issued stay in RAM. The partial pixel is discarded. The new offset is latched, `idx<=0`, go to `B0`.
  - `in_done` asserted without the completing byte, or the completing byte arrives without `in_done`: completion still follows the internal count.
    - In the first case, `in_done` is otherwise ignored.
- `offset_inclk` and `inclk` in the same cycle: the offset wins and the data byte is dropped. This case is a violation only if the state is not `IDLE`.
- Reset (`rst_n` low, at any time, including mid-packet): state `IDLE`, `idx=0`, `offset_q=0`, `hold=0`, `nib=0`. All outputs are 0.

## Timing
- Latency: `ram_we` asserts one cycle after the `inclk` of the byte that completes a pixel (byte1 or byte2). `ram_addr` and `ram_din` are valid in that same cycle.
- `pkt_done` (and `frame_done` if applicable) asserts in the same cycle as the final `ram_we`.
- `err` asserts one cycle after the offending strobe.
- Back-to-back strobes at one byte per cycle are supported with no stall.
  - There is no backpressure; the RAM must accept one write per cycle.
- Arbitrary idle gaps between strobes are allowed. All outputs return to 0 the cycle after a pulse.
- `ram_addr` = {offset_q, idx}. `ram_addr` and `ram_din` hold their last value when `ram_we` is low.
- Asynchronous reset takes effect immediately. Release on any edge must not produce a spurious write.

## Test plan
- Offset 0x05, then 768 back-to-back bytes cycling 0xAB,0xCD,0xEF, with `in_done` on the last byte.
  - Required: 512 writes, addresses 0x00A00..0x00BFF.
  - Even-index data 0xABC, odd-index data 0xDEF.
  - One `pkt_done` with the last write; no `frame_done`, no `err`.
- Offset 0xFF, then 768 bytes with random 0-5 cycle gaps.
  - Required: each write arrives 1 cycle after its completing byte.
  - Last address 0x1FFFF; `pkt_done` and `frame_done` both pulse.
- Offset 0x01, 100 bytes, then offset 0x02, then 768 bytes.
  - Required: 66 writes at 0x00200..0x00241 and one `err`.
  - Then 512 writes at 0x00400..0x005FF and one `pkt_done`.
- 3 bytes with no prior offset.
  - Required: 3 `err` pulses, no writes, state remains `IDLE`.
- `rst_n` low for 1 cycle at byte 400 of a packet, then a fresh full packet with offset 0x10.
  - Required: outputs are 0 during reset and no partial write follows.
  - The new packet writes 0x02000..0x021FF cleanly.
- `offset_inclk` and `inclk` in the same cycle while `IDLE`.
  - Required: offset latched, byte dropped, no `err`, the next byte is treated as byte0.
